data_ram_wb: RTL and testbench
==============================

// Module: data_ram_wb
// PURPOSE
//  Wishbone B4 classic slave data memory: the responding end of the load/store path driven by the MEM stage.
//  Accepts one word/halfword/byte access at a time, inserts WAIT_STATES wait cycles, then returns ack or err.
//  Writes commit on the ack cycle only. Big-endian lanes: sel[3]=dat[31:24]=byte offset 0.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of memory depth in 32-bit words (default 4 KiB)
//  WAIT_STATES  1   wait cycles between accept and ack/err (0..15)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   reset, asynchronous, active-low (0 = reset); `RstEnable is not used here
//  wb_cyc_i   in   1   bus cycle in progress
//  wb_stb_i   in   1   strobe: request valid
//  wb_we_i    in   1   1 = store, 0 = load
//  wb_adr_i   in   32  byte address; [1:0] ignored, word index = adr[DEPTH_LOG2+1:2]
//  wb_sel_i   in   4   byte-lane enables
//  wb_dat_i   in   32  store data
//  wb_dat_o   out  32  load data, valid only while wb_ack_o=1 for a load, else 0
//  wb_ack_o   out  1   one-cycle completion pulse
//  wb_err_o   out  1   one-cycle error pulse (replaces ack)
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, latched req regs=0.
//   Memory contents are not reset. Reset mid-access drops it: no write, no ack.
//  FSM (registered outputs): IDLE, WAIT, RESP, GAP.
//   IDLE: cyc&stb at edge -> latch adr/we/sel/dat; check legality; cnt<=WAIT_STATES;
//         -> WAIT if WAIT_STATES>0, else RESP.
//   WAIT: cnt decrements each cycle; at cnt==1 -> RESP.
//   RESP: legal -> ack_o=1 (store: masked write; load: dat_o=mem[idx]);
//         illegal -> err_o=1, no write, dat_o=0. Next -> GAP.
//   GAP: one cycle, ack/err=0; -> IDLE.
//  Latency: request sampled at edge N -> ack/err high during cycle N+1+WAIT_STATES.
//   Max throughput: one access per WAIT_STATES+3 cycles.
//  Legality (checked on latched values):
//   sel in {1000,0100,0010,0001,1100,0011,1111};
//   adr[31:DEPTH_LOG2+2]==0; adr[1:0] matches sel (byte: any; half: adr[0]=0; word: adr[1:0]=0).
//   Otherwise err.
//  Store: only bytes with sel=1 change; other bytes of the word keep their value.
//  Load: dat_o returns the full word; unselected lanes are driven 0.
//  Abort: cyc_i=0 in WAIT or RESP-entry cycle -> go to GAP, no write, no ack/err.
//   Sampled on the edge that would enter RESP.
//  stb_i while not IDLE is ignored: no queueing.
//  WAIT_STATES=0: IDLE->RESP directly; abort window is the accept cycle only.
//  Read-after-write to the same word in the next access returns the new data (no forwarding needed, GAP covers it).
// STRUCTURE
//  Shared defines file: WbSel* lane patterns, WbIdle/WbWait/WbResp/WbGap state codes (2 bits).
//  Sub-module dmem_array: single-port sync RAM, 2^DEPTH_LOG2 x 32, 4-bit byte write enable, registered read.
//  The FSM issues the read one cycle before RESP so data is aligned with ack.
//  Top holds the FSM, wait counter, latch regs, legality check, output muxing.
// TESTING
//  1 Reset: rst=0 mid-WAIT of store 0xDEADBEEF @0x10 -> no ack; after release, load @0x10 returns prior value.
//  2 Word: store 0x12345678 @0x20 sel=1111, then load @0x20 -> ack exactly 2 cycles after accept (W=1), dat_o=0x12345678.
//  3 Byte/half: store 0xAA000000 sel=1000 @0x20, then 0x0000BBCC sel=0011 @0x22 -> load sel=1111 gives 0xAA34BBCC.
//  4 Errors: sel=0110, sel=1111 @0x21, adr=0x0000_1000 (DEPTH_LOG2=10) -> err pulse 1 cycle, no ack, memory unchanged.
//  5 Abort: drop cyc_i one cycle after accepting store @0x30 -> no ack/err; load @0x30 unchanged; next request accepted after GAP.
//  6 Back-to-back with stb held high, W=0 and W=3 -> ack spacing exactly W+3 cycles, no double ack, stb ignored in GAP.

Source files
------------

// File: rtl/data_ram_wb_pkg.sv
// Shared definitions for the Wishbone data memory: FSM state codes, byte-lane
// patterns and small helpers for lane legality and lane masking.
package data_ram_wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_RESP = 2'd2,
        WB_GAP  = 2'd3
    } wb_state_e;

    // Big-endian lanes: sel[3] carries byte offset 0 on dat[31:24].
    localparam logic [3:0] WB_SEL_B0 = 4'b1000;
    localparam logic [3:0] WB_SEL_B1 = 4'b0100;
    localparam logic [3:0] WB_SEL_B2 = 4'b0010;
    localparam logic [3:0] WB_SEL_B3 = 4'b0001;
    localparam logic [3:0] WB_SEL_H0 = 4'b1100;
    localparam logic [3:0] WB_SEL_H1 = 4'b0011;
    localparam logic [3:0] WB_SEL_W  = 4'b1111;

    // Lane pattern must be a byte, an aligned halfword or a full word.
    function automatic logic sel_fits(input logic [3:0] sel, input logic [1:0] adr_lo);
        case (sel)
            WB_SEL_B0, WB_SEL_B1, WB_SEL_B2, WB_SEL_B3: return 1'b1;
            WB_SEL_H0, WB_SEL_H1:                       return !adr_lo[0];
            WB_SEL_W:                                   return adr_lo == 2'b00;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/data_ram_wb_dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port (read-before-write on the same address).
module dmem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1 << AW) - 1];

    // NOTE: the array has no reset; clearing it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/data_ram_wb.sv
// Wishbone B4 classic slave data memory: one access at a time, WAIT_STATES
// wait cycles, then a single-cycle ack or err followed by a one-cycle gap.
module data_ram_wb
    import data_ram_wb_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int         AW       = DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    wb_state_e   state_q;
    logic [3:0]  cnt_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [31:0] wdat_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] dat_q;

    logic          legal;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata;

    assign legal = sel_fits(sel_q, adr_q[1:0]) && (adr_q[31:AW+2] == '0);

    // While idle the RAM reads the incoming address so load data is ready
    // by RESP even with zero wait states; afterwards it follows the latch.
    always_comb begin
        ram_addr = (state_q == WB_IDLE) ? wb_adr_i[AW+1:2] : adr_q[AW+1:2];
        ram_be   = '0;
        if (state_q == WB_RESP && wb_cyc_i && legal && we_q) begin
            ram_be = sel_q;
        end
    end

    dmem_array #(.AW(AW)) u_dmem (
        .clk     (clk),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (wdat_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            case (state_q)
                WB_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_q   <= wb_adr_i;
                        sel_q   <= wb_sel_i;
                        we_q    <= wb_we_i;
                        wdat_q  <= wb_dat_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_STATES == 0) ? WB_RESP : WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!wb_cyc_i) begin
                        state_q <= WB_GAP;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= WB_RESP;
                    end
                end
                WB_RESP: begin
                    state_q <= WB_GAP;
                    // A master that dropped cyc gets neither a write nor a response.
                    if (wb_cyc_i) begin
                        if (legal) begin
                            ack_q <= 1'b1;
                            if (!we_q) begin
                                dat_q <= ram_rdata & lane_mask(sel_q);
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WB_GAP: begin
                    state_q <= WB_IDLE;
                end
                default: begin
                    state_q <= WB_IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_data_ram_wb.sv
// Scoreboard bench for data_ram_wb: three instances (1, 0 and 3 wait states)
// checked against a byte-offset memory model built from the bus rules.
module tb_data_ram_wb;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] adr   [3];
    logic [3:0]  sel   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic        ack   [3];
    logic        err   [3];

    exp_t        exp_q [3][$];
    logic [31:0] mem_m [3][1024];
    logic [31:0] init_val [3][16];
    int          checks;
    int          errors;
    int          cycle_cnt;
    exp_t        mon_e;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_ram_wb #(
            .DEPTH_LOG2  (10),
            .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .wb_cyc_i (cyc[g]),
            .wb_stb_i (stb[g]),
            .wb_we_i  (we[g]),
            .wb_adr_i (adr[g]),
            .wb_sel_i (sel[g]),
            .wb_dat_i (dat_w[g]),
            .wb_dat_o (dat_r[g]),
            .wb_ack_o (ack[g]),
            .wb_err_o (err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int ws(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // Legal accesses: a byte anywhere, an even-addressed halfword, a
    // word-aligned word, all inside the 4 KiB window.
    function automatic bit legal_m(input logic [3:0] s, input logic [31:0] a);
        int size;
        case (s)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: size = 1;
            4'b1100, 4'b0011:                   size = 2;
            4'b1111:                            size = 4;
            default:                            return 1'b0;
        endcase
        if (a >= 32'h1000) return 1'b0;
        return (a % size) == 0;
    endfunction

    // Monitor: every response the DUTs present is matched against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (ack[k] || err[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp dut=%0d ack=%0b err=%0b required no response",
                                 k, ack[k], err[k]);
                    end else begin
                        mon_e = exp_q[k].pop_front();
                        check("resp_err", 32'(err[k]), 32'(mon_e.is_err));
                        check("resp_ack", 32'(ack[k]), 32'(!mon_e.is_err));
                        check("resp_data", dat_r[k], mon_e.data);
                    end
                end
            end
        end
    end

    // One complete access; expectation is computed and queued before issue.
    task automatic access(input int k, input bit we_i, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] got);
        exp_t e;
        int   lat;
        int   idx;
        idx      = (a / 4) % 1024;
        e.is_err = !legal_m(s, a);
        e.data   = '0;
        for (int o = 0; o < 4; o++) begin
            if (!e.is_err && s[3-o]) begin
                if (we_i) mem_m[k][idx][31-8*o -: 8] = d[31-8*o -: 8];
                else      e.data[31-8*o -: 8] = mem_m[k][idx][31-8*o -: 8];
            end
        end
        exp_q[k].push_back(e);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = we_i; adr[k] = a; sel[k] = s; dat_w[k] = d;
        @(posedge clk);
        #1 stb[k] = 1'b0;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            if (ack[k] || err[k]) break;
        end
        check("latency", lat, ws(k) + 1);
        got = dat_r[k];
        @(posedge clk);
        #1 cyc[k] = 1'b0;
    endtask

    // Accepted request whose cycle is dropped right after the accept edge.
    task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] d);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = a; sel[k] = 4'b1111; dat_w[k] = d;
        @(posedge clk);
        #1 cyc[k] = 1'b0; stb[k] = 1'b0;
        repeat (ws(k) + 4) begin
            @(negedge clk);
            check("abort_no_resp", 32'(ack[k] | err[k]), 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Loads with stb held high: responses must be exactly W+3 cycles apart.
    task automatic back_to_back(input int k, input int m);
        exp_t e;
        int   prev;
        int   t;
        logic [31:0] got;
        access(k, 1'b1, 32'h14, 4'b1111, 32'h0BAD_CA00 + k, got);
        e.is_err = 1'b0;
        e.data   = 32'h0BAD_CA00 + k;
        for (int i = 0; i < m; i++) exp_q[k].push_back(e);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; adr[k] = 32'h14; sel[k] = 4'b1111;
        prev = 0;
        for (int i = 0; i < m; i++) begin
            for (t = 0; t < 40; t++) begin
                @(negedge clk);
                if (ack[k]) break;
            end
            if (t == 40) check("b2b_timeout", 1, 0);
            if (i > 0) check("b2b_spacing", cycle_cnt - prev, ws(k) + 3);
            prev = cycle_cnt;
        end
        @(posedge clk);
        #1 cyc[k] = 1'b0; stb[k] = 1'b0;
        repeat (ws(k) + 4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        logic [3:0]  sel_tab [10];
        logic [31:0] a;
        checks = 0; errors = 0; cycle_cnt = 0;
        sel_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100,
                    4'b0011, 4'b1111, 4'b0110, 4'b1010, 4'b0000};
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0; sel[k] = '0; dat_w[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ack", 32'(ack[k]), 0);
            check("reset_err", 32'(err[k]), 0);
            check("reset_dat", dat_r[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                init_val[k][w] = $urandom;
                access(k, 1'b1, 32'(w * 4), 4'b1111, init_val[k][w], got);
            end
        end

        // Full-word store then load.
        access(0, 1'b1, 32'h20, 4'b1111, 32'h1234_5678, got);
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, got);
        check("word_load", got, 32'h1234_5678);

        // Byte and halfword merges into the same word.
        access(0, 1'b1, 32'h20, 4'b1000, 32'hAA00_0000, got);
        access(0, 1'b1, 32'h22, 4'b0011, 32'h0000_BBCC, got);
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, got);
        check("merge_load", got, 32'hAA34_BBCC);
        access(0, 1'b0, 32'h22, 4'b0011, 32'h0, got);
        check("half_load_lanes", got, 32'h0000_BBCC);

        // Illegal accesses: bad lane pattern, misaligned word, out of range.
        access(0, 1'b1, 32'h20, 4'b0110, 32'hFFFF_FFFF, got);
        access(0, 1'b1, 32'h21, 4'b1111, 32'hFFFF_FFFF, got);
        access(0, 1'b1, 32'h1000, 4'b1111, 32'hFFFF_FFFF, got);
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, got);
        check("err_keeps_word", got, 32'hAA34_BBCC);
        access(0, 1'b0, 32'h0, 4'b1111, 32'h0, got);
        check("err_no_alias", got, init_val[0][0]);

        // Reset in the middle of a store drops it.
        access(0, 1'b1, 32'h10, 4'b1111, 32'h1122_3344, got);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; sel[0] = 4'b1111;
        dat_w[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 stb[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        cyc[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_ack", 32'(ack[0] | err[0]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, got);
        check("rst_mem_kept", got, 32'h1122_3344);

        // Abort on each instance, then the word must be untouched.
        for (int k = 0; k < 3; k++) begin
            access(k, 1'b1, 32'h30, 4'b1111, 32'h5566_7788, got);
            abort_store(k, 32'h30, 32'hCAFE_F00D);
            access(k, 1'b0, 32'h30, 4'b1111, 32'h0, got);
            check("abort_mem_kept", got, 32'h5566_7788);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 30; i++) begin
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
                access(k, 1'($urandom_range(0, 1)), a, sel_tab[$urandom_range(0, 9)], $urandom, got);
            end
        end

        for (int k = 0; k < 3; k++) back_to_back(k, 4);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) check("queue_empty", exp_q[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
